// File: rtl/reg_pkg.sv
`default_nettype none
// ============================================================================
// Package     : reg_pkg
// Description : Shared types for the CPU register file: register selectors,
//               ALU flag bundle, privilege mode and the status word.
// Revision    : 1.0 - initial release
// ============================================================================
package reg_pkg;

    // Architectural register selectors; R0..R12 and FP are general purpose.
    typedef enum logic [3:0] {
        R0, R1, R2, R3, R4, R5, R6, R7,
        R8, R9, R10, R11, R12, FP, SP, PC
    } reg_e;

    // Number of plain storage registers (R0..R12 plus FP).
    localparam int NUM_GPR = 14;

    typedef enum logic {
        MODE_KERNEL = 1'b0,
        MODE_USER   = 1'b1
    } cpu_mode_e;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } alu_status_t;

    typedef struct packed {
        cpu_mode_e   mode;
        logic        imask;
        alu_status_t alu_status;
    } status_t;

    // Kernel mode, interrupts masked, all flags clear.
    localparam status_t STATUS_RESET = '{
        mode:       MODE_KERNEL,
        imask:      1'b1,
        alu_status: '0
    };

endpackage : reg_pkg
`default_nettype wire

// File: rtl/status_reg.sv
`default_nettype none
// ============================================================================
// Module      : status_reg
// Description : Status register with a single saved slot for interrupt
//               entry/return. Exports the current mode for SP banking.
// Revision    : 1.0 - initial release
// ============================================================================
module status_reg
    import reg_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_int_enter,
    input  logic        i_int_return,
    input  logic        i_status_we,
    input  status_t     i_status_in,
    input  logic        i_alu_status_we,
    input  alu_status_t i_alu_status_in,
    output status_t     o_status,
    output cpu_mode_e   o_mode
);

    status_t r_status;
    status_t r_saved;
    status_t w_status_nxt;
    status_t w_saved_nxt;

    // Next-state selection: interrupt entry beats return beats full write
    // beats a flags-only update.
    always_comb begin
        w_status_nxt = r_status;
        w_saved_nxt  = r_saved;
        if (i_int_enter) begin
            // Only one saved slot: a nested entry overwrites it.
            w_saved_nxt        = r_status;
            w_status_nxt.mode  = MODE_KERNEL;
            w_status_nxt.imask = 1'b1;
        end else if (i_int_return) begin
            w_status_nxt = r_saved;
        end else if (i_status_we) begin
            w_status_nxt = i_status_in;
        end else if (i_alu_status_we) begin
            w_status_nxt.alu_status = i_alu_status_in;
        end
    end

    // Status and saved-status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_status <= STATUS_RESET;
            r_saved  <= STATUS_RESET;
        end else begin
            r_status <= w_status_nxt;
            r_saved  <= w_saved_nxt;
        end
    end

    assign o_status = r_status;
    assign o_mode   = r_status.mode;

endmodule : status_reg
`default_nettype wire

// File: rtl/reg_file.sv
`default_nettype none
// ============================================================================
// Module      : reg_file
// Description : CPU architectural register file: R0-R12/FP storage, PC with
//               increment, banked kernel/user SP with push/pop adjust, two
//               combinational read ports and one write port.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_file
    import reg_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_PC  = '0,
    parameter logic [WIDTH-1:0] RESET_KSP = '0,
    parameter logic [WIDTH-1:0] RESET_USP = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  reg_e             sel_a,
    input  reg_e             sel_b,
    output logic [WIDTH-1:0] data_a,
    output logic [WIDTH-1:0] data_b,
    input  logic             we,
    input  reg_e             sel_w,
    input  logic [WIDTH-1:0] data_w,
    input  logic             pc_inc,
    input  logic             sp_inc,
    input  logic             sp_dec,
    input  logic             alu_status_we,
    input  alu_status_t      alu_status_in,
    input  logic             status_we,
    input  status_t          status_in,
    input  logic             int_enter,
    input  logic             int_return,
    output status_t          status,
    output logic [WIDTH-1:0] pc
);

    logic [WIDTH-1:0] r_gpr [NUM_GPR];
    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_ksp;
    logic [WIDTH-1:0] r_usp;

    cpu_mode_e        w_mode;
    logic [WIDTH-1:0] w_sp_cur;
    logic [WIDTH-1:0] w_sp_nxt;
    logic [WIDTH-1:0] w_pc_nxt;
    logic             w_wr_gpr;

    status_reg u_status_reg (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_int_enter     (int_enter),
        .i_int_return    (int_return),
        .i_status_we     (status_we),
        .i_status_in     (status_in),
        .i_alu_status_we (alu_status_we),
        .i_alu_status_in (alu_status_in),
        .o_status        (status),
        .o_mode          (w_mode)
    );

    // Bank select uses the pre-edge mode, so a mode change only affects
    // SP accesses from the following cycle on.
    assign w_sp_cur = (w_mode == MODE_KERNEL) ? r_ksp : r_usp;
    assign w_wr_gpr = we && (sel_w != SP) && (sel_w != PC);

    // Active SP next value: explicit write, then push, then pop; push and
    // pop together cancel out.
    always_comb begin
        w_sp_nxt = w_sp_cur;
        if (we && (sel_w == SP)) begin
            w_sp_nxt = data_w;
        end else if (sp_dec && !sp_inc) begin
            w_sp_nxt = w_sp_cur - 1'b1;
        end else if (sp_inc && !sp_dec) begin
            w_sp_nxt = w_sp_cur + 1'b1;
        end
    end

    // PC next value: explicit write beats increment.
    always_comb begin
        w_pc_nxt = r_pc;
        if (we && (sel_w == PC)) begin
            w_pc_nxt = data_w;
        end else if (pc_inc) begin
            w_pc_nxt = r_pc + 1'b1;
        end
    end

    // General-purpose storage; R0 is an ordinary writable register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_GPR; i++) begin
                r_gpr[i] <= '0;
            end
        end else if (w_wr_gpr) begin
            r_gpr[sel_w] <= data_w;
        end
    end

    // PC and the two SP banks; only the bank for the current mode moves.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc  <= RESET_PC;
            r_ksp <= RESET_KSP;
            r_usp <= RESET_USP;
        end else begin
            r_pc <= w_pc_nxt;
            if (w_mode == MODE_KERNEL) begin
                r_ksp <= w_sp_nxt;
            end else begin
                r_usp <= w_sp_nxt;
            end
        end
    end

    // Read port A: current state only, no bypass of a same-cycle write.
    always_comb begin
        data_a = '0;
        case (sel_a)
            PC:      data_a = r_pc;
            SP:      data_a = w_sp_cur;
            default: data_a = r_gpr[sel_a];
        endcase
    end

    // Read port B: identical to port A.
    always_comb begin
        data_b = '0;
        case (sel_b)
            PC:      data_b = r_pc;
            SP:      data_b = w_sp_cur;
            default: data_b = r_gpr[sel_b];
        endcase
    end

    assign pc = r_pc;

endmodule : reg_file
`default_nettype wire

// File: tb/tb_reg_file.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_file
// Description : Self-checking bench for reg_file: directed vector table,
//               directed status/interrupt sequences, randomized traffic
//               against a behavioural model, and an asynchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_file;
    import reg_pkg::*;

    localparam logic [31:0] C_RST_PC  = 32'h0000_0100;
    localparam logic [31:0] C_RST_KSP = 32'h0000_FFF0;
    localparam logic [31:0] C_RST_USP = 32'h0000_2000;

    logic        clk;
    logic        rst_n;
    reg_e        sel_a, sel_b, sel_w;
    logic [31:0] data_a, data_b, data_w, pc;
    logic        we, pc_inc, sp_inc, sp_dec;
    logic        alu_status_we, status_we, int_enter, int_return;
    alu_status_t alu_status_in;
    status_t     status_in;
    status_t     status;

    int n_vec = 0;
    int n_bad = 0;

    // Behavioural model state (mode: 0 kernel, 1 user).
    logic [31:0] m_r [14];
    logic [31:0] m_pc, m_ksp, m_usp;
    logic        m_mode, m_imask, s_mode, s_imask;
    logic [3:0]  m_flags, s_flags;

    reg_file #(
        .WIDTH     (32),
        .RESET_PC  (C_RST_PC),
        .RESET_KSP (C_RST_KSP),
        .RESET_USP (C_RST_USP)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .sel_a         (sel_a),
        .sel_b         (sel_b),
        .data_a        (data_a),
        .data_b        (data_b),
        .we            (we),
        .sel_w         (sel_w),
        .data_w        (data_w),
        .pc_inc        (pc_inc),
        .sp_inc        (sp_inc),
        .sp_dec        (sp_dec),
        .alu_status_we (alu_status_we),
        .alu_status_in (alu_status_in),
        .status_we     (status_we),
        .status_in     (status_in),
        .int_enter     (int_enter),
        .int_return    (int_return),
        .status        (status),
        .pc            (pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        reg_e        sel_w;
        logic [31:0] data_w;
        logic        pc_inc;
        logic        sp_inc;
        logic        sp_dec;
        reg_e        sel_a;
        logic [31:0] exp_pre;
        logic [31:0] exp_post;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic idle();
        we = 0; pc_inc = 0; sp_inc = 0; sp_dec = 0;
        alu_status_we = 0; status_we = 0; int_enter = 0; int_return = 0;
        data_w = '0; sel_w = R0;
        alu_status_in = '0; status_in = '0;
    endtask

    task automatic m_reset();
        for (int i = 0; i < 14; i++) m_r[i] = '0;
        m_pc = C_RST_PC; m_ksp = C_RST_KSP; m_usp = C_RST_USP;
        m_mode = 0; m_imask = 1; m_flags = 4'h0;
        s_mode = 0; s_imask = 1; s_flags = 4'h0;
    endtask

    function automatic logic [31:0] exp_read(input int i);
        if (i == 15) return m_pc;
        if (i == 14) return m_mode ? m_usp : m_ksp;
        return m_r[i];
    endfunction

    // Apply one clock edge's worth of the architectural rules to the model.
    task automatic model_step();
        int          w = int'(sel_w);
        logic [31:0] sp;
        logic        n_mode, n_imask;
        logic [3:0]  n_flags;
        sp = m_mode ? m_usp : m_ksp;
        if (we && w == 14) sp = data_w;
        else               sp = sp + 32'(sp_inc) - 32'(sp_dec);
        if (m_mode) m_usp = sp; else m_ksp = sp;
        if (we && w == 15) m_pc = data_w;
        else if (pc_inc)   m_pc = m_pc + 1;
        if (we && w < 14)  m_r[w] = data_w;
        n_mode = m_mode; n_imask = m_imask; n_flags = m_flags;
        if (int_enter) begin
            s_mode = m_mode; s_imask = m_imask; s_flags = m_flags;
            n_mode = 0; n_imask = 1;
        end else if (int_return) begin
            n_mode = s_mode; n_imask = s_imask; n_flags = s_flags;
        end else if (status_we) begin
            n_mode = (status_in.mode == MODE_USER); n_imask = status_in.imask;
            n_flags = status_in.alu_status;
        end else if (alu_status_we) begin
            n_flags = alu_status_in;
        end
        m_mode = n_mode; m_imask = n_imask; m_flags = n_flags;
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        idle();
    endtask

    task automatic chk_status(input string nm, input logic md, input logic im, input logic [3:0] fl);
        chk({nm, ".mode"},  32'(status.mode == MODE_USER), 32'(md));
        chk({nm, ".imask"}, 32'(status.imask), 32'(im));
        chk({nm, ".flags"}, 32'(status.alu_status), 32'(fl));
    endtask

    task automatic sweep(input string nm);
        idle();
        for (int i = 0; i < 16; i++) begin
            sel_a = reg_e'(4'(i));
            sel_b = reg_e'(4'(15 - i));
            #1;
            chk({nm, ".a"}, data_a, exp_read(i));
            chk({nm, ".b"}, data_b, exp_read(15 - i));
        end
        chk({nm, ".pc"}, pc, m_pc);
        chk_status(nm, m_mode, m_imask, m_flags);
    endtask

    initial begin
        tbl[0]  = '{1, R5,  32'hDEAD_BEEF, 0, 0, 0, R5, 32'h0,         32'hDEAD_BEEF};
        tbl[1]  = '{1, R0,  32'h0000_1234, 0, 0, 0, R0, 32'h0,         32'h0000_1234};
        tbl[2]  = '{1, FP,  32'h0000_CAFE, 0, 0, 0, FP, 32'h0,         32'h0000_CAFE};
        tbl[3]  = '{1, PC,  32'hFFFF_FFFF, 0, 0, 0, PC, 32'h0000_0100, 32'hFFFF_FFFF};
        tbl[4]  = '{0, R0,  32'h0,         1, 0, 0, PC, 32'hFFFF_FFFF, 32'h0};
        tbl[5]  = '{1, PC,  32'h0000_0040, 1, 0, 0, PC, 32'h0,         32'h0000_0040};
        tbl[6]  = '{1, SP,  32'h0000_1000, 0, 0, 0, SP, 32'h0000_FFF0, 32'h0000_1000};
        tbl[7]  = '{0, R0,  32'h0,         0, 0, 1, SP, 32'h0000_1000, 32'h0000_0FFF};
        tbl[8]  = '{0, R0,  32'h0,         0, 1, 1, SP, 32'h0000_0FFF, 32'h0000_0FFF};
        tbl[9]  = '{0, R0,  32'h0,         0, 1, 0, SP, 32'h0000_0FFF, 32'h0000_1000};
        tbl[10] = '{1, SP,  32'h0000_0005, 0, 0, 1, SP, 32'h0000_1000, 32'h0000_0005};
        tbl[11] = '{1, R12, 32'h0000_0077, 1, 0, 0, PC, 32'h0000_0040, 32'h0000_0041};

        // Power-on reset.
        idle();
        sel_a = SP; sel_b = R0;
        rst_n = 1'b0;
        m_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("reset.pc", pc, C_RST_PC);
        chk("reset.ksp", data_a, C_RST_KSP);
        chk("reset.r0", data_b, 32'h0);
        chk_status("reset", 0, 1, 4'h0);

        // Directed vector table: old value before the edge, new value after.
        for (int i = 0; i < 12; i++) begin
            we = tbl[i].we; sel_w = tbl[i].sel_w; data_w = tbl[i].data_w;
            pc_inc = tbl[i].pc_inc; sp_inc = tbl[i].sp_inc; sp_dec = tbl[i].sp_dec;
            sel_a = tbl[i].sel_a;
            #1;
            chk($sformatf("tbl[%0d].pre", i), data_a, tbl[i].exp_pre);
            cyc();
            chk($sformatf("tbl[%0d].post", i), data_a, tbl[i].exp_post);
        end
        sweep("after_tbl");

        // Switch to user mode; push then moves USP and leaves KSP alone.
        status_we = 1;
        status_in = '{mode: MODE_USER, imask: 1'b0, alu_status: 4'b0101};
        cyc();
        chk_status("to_user", 1, 0, 4'b0101);
        sp_dec = 1;
        cyc();
        sel_a = SP; #1;
        chk("usp_dec", data_a, C_RST_USP - 1);

        // Interrupt entry, flags update in handler, return.
        int_enter = 1;
        cyc();
        chk_status("enter", 0, 1, 4'b0101);
        sel_a = SP; #1;
        chk("ksp_kept", data_a, 32'h0000_0005);
        alu_status_we = 1; alu_status_in = 4'b1000;
        cyc();
        chk_status("alu_we", 0, 1, 4'b1000);
        int_return = 1;
        cyc();
        chk_status("return", 1, 0, 4'b0101);
        sel_a = SP; #1;
        chk("usp_back", data_a, C_RST_USP - 1);

        // All status sources at once: entry alone takes effect.
        int_enter = 1; int_return = 1; status_we = 1; alu_status_we = 1;
        status_in = '{mode: MODE_USER, imask: 1'b0, alu_status: 4'b1111};
        alu_status_in = 4'b1010;
        cyc();
        chk_status("all_high", 0, 1, 4'b0101);
        int_return = 1;
        cyc();
        chk_status("all_high_ret", 1, 0, 4'b0101);

        // Nested entry overwrites the single saved slot.
        int_enter = 1; cyc();
        int_enter = 1; cyc();
        int_return = 1; cyc();
        chk_status("nested_ret", 0, 1, 4'b0101);
        sweep("after_int");

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            we         = ($urandom_range(2, 0) == 0);
            sel_w      = reg_e'(4'($urandom_range(15, 0)));
            data_w     = $urandom;
            pc_inc     = $urandom_range(1, 0) == 1;
            sp_inc     = $urandom_range(2, 0) == 0;
            sp_dec     = $urandom_range(2, 0) == 0;
            int_enter  = $urandom_range(9, 0) == 0;
            int_return = $urandom_range(9, 0) == 0;
            status_we  = $urandom_range(9, 0) == 0;
            alu_status_we = $urandom_range(3, 0) == 0;
            status_in  = status_t'(6'($urandom));
            alu_status_in = alu_status_t'(4'($urandom));
            sel_a      = reg_e'(4'($urandom_range(15, 0)));
            sel_b      = reg_e'(4'($urandom_range(15, 0)));
            #1;
            chk("rnd.a", data_a, exp_read(int'(sel_a)));
            chk("rnd.b", data_b, exp_read(int'(sel_b)));
            chk("rnd.pc", pc, m_pc);
            chk_status("rnd", m_mode, m_imask, m_flags);
            cyc();
        end
        sweep("after_rnd");

        // Asynchronous reset mid-operation with a write pending.
        we = 1; sel_w = R1; data_w = 32'h0000_ABCD; pc_inc = 1;
        sel_a = SP; sel_b = R5;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async.pc", pc, C_RST_PC);
        chk("async.sp", data_a, C_RST_KSP);
        chk("async.r5", data_b, 32'h0);
        chk_status("async", 0, 1, 4'h0);
        @(posedge clk);
        @(negedge clk);
        m_reset();
        idle();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        sweep("after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule : tb_reg_file
`default_nettype wire
